// File: rtl/axis_dac_ramp_gen_if.sv
// AXI-Stream link between the ramp generator and the dual interleaved DAC stage.
// Channel A sits in tdata[15:0], channel B in tdata[31:16].
interface axis_dac_ramp_gen_if;
    localparam int unsigned TDATA_W = 32;

    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_dac_ramp_gen.sv
// Dual-channel sawtooth/triangle generator streaming packed DAC samples over AXIS.
// Configuration is captured on an accepted start; samples advance once per divider period.
module axis_dac_ramp_gen #(
    parameter int unsigned DAC_DATA_WIDTH = 14,
    parameter int unsigned DIV_WIDTH      = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cfg_start,
    input  logic                      cfg_stop,
    input  logic                      cfg_triangle,
    input  logic [DIV_WIDTH-1:0]      cfg_divider,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_step_a,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_step_b,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_min,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_max,
    output logic                      busy,
    output logic                      overrun,
    output logic                      cfg_error,
    axis_dac_ramp_gen_if.master       m_axis
);
    localparam int unsigned W       = DAC_DATA_WIDTH;
    localparam int unsigned TDATA_W = 32;
    localparam int unsigned LANE_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 triangle_q, triangle_d;
    logic [W-1:0]         step_a_q, step_a_d;
    logic [W-1:0]         step_b_q, step_b_d;
    logic [W-1:0]         min_q, min_d;
    logic [W-1:0]         max_q, max_d;
    logic [W-1:0]         acc_a_q, acc_a_d;
    logic [W-1:0]         acc_b_q, acc_b_d;
    logic                 down_a_q, down_a_d;
    logic                 down_b_q, down_b_d;
    logic                 tvalid_q, tvalid_d;
    logic [TDATA_W-1:0]   tdata_q, tdata_d;
    logic                 overrun_q, overrun_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 busy_q, busy_d;

    logic                 start_ok_c;
    logic                 start_bad_c;
    logic                 pending_c;
    logic                 handshake_c;
    logic                 tick_c;
    logic [W:0]           next_a_c;
    logic [W:0]           next_b_c;

    // Returns {down_next, value_next}; sums carry one extra bit so they never wrap.
    function automatic logic [W:0] ramp_next(
        input logic [W-1:0] acc,
        input logic [W-1:0] step,
        input logic [W-1:0] lo,
        input logic [W-1:0] hi,
        input logic         triangle,
        input logic         down
    );
        logic [W:0]          sum;
        logic signed [W+1:0] dif;
        logic [W-1:0]        val;
        logic                dn;
        sum = {1'b0, acc} + {1'b0, step};
        dif = $signed({2'b00, acc}) - $signed({2'b00, step});
        val = sum[W-1:0];
        dn  = down;
        if (!triangle) begin
            if (sum > {1'b0, hi}) begin
                val = lo;
            end
        end else if (!down) begin
            if (sum >= {1'b0, hi}) begin
                val = hi;
                dn  = 1'b1;
            end
        end else begin
            if (dif <= $signed({2'b00, lo})) begin
                val = lo;
                dn  = 1'b0;
            end else begin
                val = dif[W-1:0];
            end
        end
        return {dn, val};
    endfunction

    function automatic logic [TDATA_W-1:0] pack_samples(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [TDATA_W-1:0] p;
        p              = '0;
        p[0 +: W]      = a;
        p[LANE_W +: W] = b;
        return p;
    endfunction

    // Event decode shared by next-state and output logic; stop beats start and tick.
    always_comb begin
        start_ok_c  = 1'b0;
        start_bad_c = 1'b0;
        if (state_q == S_IDLE && cfg_start && !cfg_stop) begin
            start_ok_c  = (cfg_min <= cfg_max);
            start_bad_c = (cfg_min > cfg_max);
        end
        pending_c   = tvalid_q && !m_axis.tready;
        handshake_c = tvalid_q && m_axis.tready;
        tick_c      = (state_q == S_RUN) && !cfg_stop && (cnt_q == div_q);
        next_a_c    = ramp_next(acc_a_q, step_a_q, min_q, max_q, triangle_q, down_a_q);
        next_b_c    = ramp_next(acc_b_q, step_b_q, min_q, max_q, triangle_q, down_b_q);
    end

    // State register plus all registered outputs and datapath.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            triangle_q  <= 1'b0;
            step_a_q    <= '0;
            step_b_q    <= '0;
            min_q       <= '0;
            max_q       <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            down_a_q    <= 1'b0;
            down_b_q    <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            overrun_q   <= 1'b0;
            cfg_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            triangle_q  <= triangle_d;
            step_a_q    <= step_a_d;
            step_b_q    <= step_b_d;
            min_q       <= min_d;
            max_q       <= max_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            down_a_q    <= down_a_d;
            down_b_q    <= down_b_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            overrun_q   <= overrun_d;
            cfg_error_q <= cfg_error_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok_c) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_stop) begin
                    state_d = pending_c ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (handshake_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        triangle_d  = triangle_q;
        step_a_d    = step_a_q;
        step_b_d    = step_b_q;
        min_d       = min_q;
        max_d       = max_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        down_a_d    = down_a_q;
        down_b_d    = down_b_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        overrun_d   = overrun_q;
        cfg_error_d = cfg_error_q;
        busy_d      = (state_d != S_IDLE);

        if (handshake_c) begin
            tvalid_d = 1'b0;
        end

        if (state_q == S_RUN) begin
            cnt_d = (cnt_q == div_q) ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        if (start_ok_c) begin
            div_d       = cfg_divider;
            triangle_d  = cfg_triangle;
            step_a_d    = cfg_step_a;
            step_b_d    = cfg_step_b;
            min_d       = cfg_min;
            max_d       = cfg_max;
            acc_a_d     = cfg_min;
            acc_b_d     = cfg_min;
            down_a_d    = 1'b0;
            down_b_d    = 1'b0;
            cnt_d       = '0;
            tvalid_d    = 1'b1;
            tdata_d     = pack_samples(cfg_min, cfg_min);
            overrun_d   = 1'b0;
            cfg_error_d = 1'b0;
        end

        if (start_bad_c) begin
            cfg_error_d = 1'b1;
        end

        // A tick with the previous beat still stalled is dropped, never queued.
        if (tick_c && !pending_c) begin
            acc_a_d  = next_a_c[W-1:0];
            down_a_d = next_a_c[W];
            acc_b_d  = next_b_c[W-1:0];
            down_b_d = next_b_c[W];
            tvalid_d = 1'b1;
            tdata_d  = pack_samples(next_a_c[W-1:0], next_b_c[W-1:0]);
        end else if (tick_c) begin
            overrun_d = 1'b1;
        end
    end

    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign cfg_error     = cfg_error_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
endmodule
